// File: rtl/sum_accumulator.sv
// sum_accumulator: collects {carry, sum} beats from param_adder into a wider
// running total and presents one result per burst (total, beat count, sticky
// overflow) behind a valid/ready handshake.
//
// Build option: define ACC_SATURATE_EN to clamp the accumulator to all-ones
// on overflow instead of wrapping modulo 2^ACC_WIDTH.
//
// ACC_WIDTH must be greater than WIDTH.
module sum_accumulator #(
    parameter int WIDTH       = 8,
    parameter int ACC_WIDTH   = 16,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_sum,
    input  logic                   in_carry,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_acc,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]   out_acc_q, out_acc_d;
    logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;
    logic                   out_ovf_q, out_ovf_d;

    logic                   beat_fire;
    logic [ACC_WIDTH:0]     operand;
    logic [ACC_WIDTH:0]     sum_wide;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic [COUNT_WIDTH-1:0] count_next;
    logic                   ovf_next;

    // Beats are taken whenever no result is waiting for the consumer.
    assign in_ready  = (state_q != DONE);
    assign beat_fire = in_valid && in_ready;

    // Datapath for one accepted beat: widened add, overflow detect, count step.
    always_comb begin
        operand  = {{(ACC_WIDTH - WIDTH){1'b0}}, in_carry, in_sum};
        sum_wide = {1'b0, acc_q} + operand;
        ovf_next = ovf_q | sum_wide[ACC_WIDTH];
`ifdef ACC_SATURATE_EN
        // Once clamped, stay clamped until the burst is handed off.
        acc_next = ovf_next ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];
`else
        acc_next = sum_wide[ACC_WIDTH-1:0];
`endif
        count_next = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_WIDTH'(1);
    end

    // Next-state and output-register logic for the burst FSM.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            IDLE, ACCUM: begin
                if (beat_fire) begin
                    acc_d   = acc_next;
                    count_d = count_next;
                    ovf_d   = ovf_next;
                    if (in_last) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_acc_d   = acc_next;
                        out_count_d = count_next;
                        out_ovf_d   = ovf_next;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            DONE: begin
                // Handshake retires the result; the next beat is taken no
                // earlier than the following cycle because in_ready is low here.
                if (out_ready) begin
                    state_d     = IDLE;
                    acc_d       = '0;
                    count_d     = '0;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b0;
                    out_acc_d   = '0;
                    out_count_d = '0;
                    out_ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_acc      = out_acc_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Testbench for sum_accumulator. Uses ACC_WIDTH = 10 so that overflow is
// reachable in short bursts. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_sum_accumulator;

    localparam int WIDTH       = 8;
    localparam int ACC_WIDTH   = 10;
    localparam int COUNT_WIDTH = 4;
    localparam longint ACC_MAX = (64'd1 << ACC_WIDTH) - 1;
    localparam int CNT_MAX     = (1 << COUNT_WIDTH) - 1;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_sum;
    logic                   in_carry;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_WIDTH-1:0]   out_acc;
    logic [COUNT_WIDTH-1:0] out_count;
    logic                   out_overflow;

    int checks;
    int errors;

    // Beat list for the burst currently being built.
    int beat_sum[$];
    int beat_carry[$];

    sum_accumulator #(
        .WIDTH      (WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .COUNT_WIDTH(COUNT_WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sum      (in_sum),
        .in_carry    (in_carry),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_acc     (out_acc),
        .out_count   (out_count),
        .out_overflow(out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole-burst arithmetic on unbounded integers. With only
    // non-negative operands the running total overflows at some beat iff the
    // final true total exceeds the accumulator range.
    task automatic model_burst(output logic [ACC_WIDTH-1:0] acc,
                               output logic [COUNT_WIDTH-1:0] cnt,
                               output logic ovf);
        longint total;
        int     n;
        total = 0;
        n     = beat_sum.size();
        for (int i = 0; i < n; i++)
            total += longint'(beat_carry[i]) * 256 + longint'(beat_sum[i]);
        ovf = (total > ACC_MAX);
`ifdef ACC_SATURATE_EN
        acc = ovf ? ACC_WIDTH'(ACC_MAX) : ACC_WIDTH'(total);
`else
        acc = ACC_WIDTH'(total % (ACC_MAX + 1));
`endif
        cnt = (n > CNT_MAX) ? COUNT_WIDTH'(CNT_MAX) : COUNT_WIDTH'(n);
    endtask

    // Present one beat at a falling edge and hold it until accepted.
    task automatic drive_beat(input int s, input int c, input bit last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_sum   = WIDTH'(s);
        in_carry = c[0];
        in_last  = last;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL beat_accept: in_ready=%0b after %0d cycles, required 1", in_ready, guard);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Send the queued beats with optional idle gaps; last flagged on the final one.
    task automatic send_burst(input bit gaps);
        for (int i = 0; i < beat_sum.size(); i++) begin
            drive_beat(beat_sum[i], beat_carry[i], i == beat_sum.size() - 1);
            if (gaps && i != beat_sum.size() - 1)
                repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    // Called right after the last beat was accepted: checks the one-cycle
    // latency, the result, stability under backpressure, and the handshake.
    task automatic finish_burst(input logic [ACC_WIDTH-1:0] e_acc,
                                input logic [COUNT_WIDTH-1:0] e_cnt,
                                input logic e_ovf, input int hold, input bit junk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: out_valid=%0b, required 1", out_valid);
        end
        checks++;
        if (out_acc !== e_acc || out_count !== e_cnt || out_overflow !== e_ovf) begin
            errors++;
            $display("FAIL result: acc=%h cnt=%0d ovf=%0b, required acc=%h cnt=%0d ovf=%0b",
                     out_acc, out_count, out_overflow, e_acc, e_cnt, e_ovf);
        end
        out_ready = 1'b0;
        if (junk) begin
            in_valid = 1'b1;
            in_sum   = WIDTH'($urandom_range(0, 255));
            in_carry = 1'b1;
            in_last  = 1'b1;
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_acc !== e_acc ||
                out_count !== e_cnt || out_overflow !== e_ovf) begin
                errors++;
                $display("FAIL hold[%0d]: valid=%0b rdy=%0b acc=%h cnt=%0d ovf=%0b, required valid=1 rdy=0 acc=%h cnt=%0d ovf=%0b",
                         k, out_valid, in_ready, out_acc, out_count, out_overflow, e_acc, e_cnt, e_ovf);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== '0 ||
            out_count !== '0 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake: valid=%0b rdy=%0b acc=%h cnt=%0d ovf=%0b, required 0 1 0 0 0",
                     out_valid, in_ready, out_acc, out_count, out_overflow);
        end
    endtask

    task automatic set_beats1(input int s, input int c);
        beat_sum.delete();
        beat_carry.delete();
        beat_sum.push_back(s);
        beat_carry.push_back(c);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_acc !== '0 || out_count !== '0 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%0b acc=%h cnt=%0d ovf=%0b, required all 0",
                     out_valid, out_acc, out_count, out_overflow);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%0b, required 1", in_ready);
        end
        // Reset in the middle of a burst.
        drive_beat(8'h40, 1, 1'b0);
        drive_beat(8'h22, 0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_acc !== '0) begin
            errors++;
            $display("FAIL reset_midburst: valid=%0b acc=%h, required 0 0", out_valid, out_acc);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%0b, required 1", in_ready);
        end
        drive_beat(8'h03, 0, 1'b1);
        finish_burst(10'h003, 4'd1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_basic();
        beat_sum   = '{8'h10, 8'hFF, 8'h01};
        beat_carry = '{0, 1, 0};
        send_burst(1'b0);
        finish_burst(10'h210, 4'd3, 1'b0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        set_beats1(8'h2A, 1);
        send_burst(1'b0);
        finish_burst(10'h12A, 4'd1, 1'b0, 5, 1'b1);
    endtask

    task automatic test_overflow();
        beat_sum   = '{8'hFF, 8'hFF, 8'h02};
        beat_carry = '{1, 1, 0};
        send_burst(1'b0);
`ifdef ACC_SATURATE_EN
        finish_burst(10'h3FF, 4'd3, 1'b1, 1, 1'b0);
`else
        finish_burst(10'h000, 4'd3, 1'b1, 1, 1'b0);
`endif
    endtask

    task automatic test_count_sat();
        beat_sum.delete();
        beat_carry.delete();
        for (int i = 0; i < 20; i++) begin
            beat_sum.push_back(1);
            beat_carry.push_back(0);
        end
        send_burst(1'b0);
        finish_burst(10'd20, 4'd15, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        set_beats1(8'h05, 0);
        send_burst(1'b0);
        finish_burst(10'h005, 4'd1, 1'b0, 0, 1'b0);
        set_beats1(8'h07, 0);
        send_burst(1'b0);
        finish_burst(10'h007, 4'd1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [ACC_WIDTH-1:0]   e_acc;
        logic [COUNT_WIDTH-1:0] e_cnt;
        logic                   e_ovf;
        int                     len;
        for (int b = 0; b < 40; b++) begin
            beat_sum.delete();
            beat_carry.delete();
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                beat_sum.push_back($urandom_range(0, 255));
                beat_carry.push_back($urandom_range(0, 1));
            end
            model_burst(e_acc, e_cnt, e_ovf);
            send_burst(1'b1);
            finish_burst(e_acc, e_cnt, e_ovf, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_carry  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_count_sat();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so a stuck handshake cannot hang the run.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
